adxl362_spi_slave: RTL and testbench

//  Upstream SPI front end for the behavioural ADXL362 model. Decodes the ADXL362 SPI protocol

---
 rtl/adxl362_spi_slave_pkg.sv | 17 +
 rtl/adxl362_spi_sync.sv | 33 +++
 rtl/adxl362_spi_slave.sv | 197 +++++++++++++++++++
 tb/tb_adxl362_spi_slave.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/adxl362_spi_slave_pkg.sv
// Shared constants and state encoding for the ADXL362 SPI front end.
package adxl362_spi_slave_pkg;

  localparam logic [7:0] ADXL362_CMD_WRITE = 8'h0A;
  localparam logic [7:0] ADXL362_CMD_READ  = 8'h0B;
  localparam logic [7:0] ADXL362_CMD_FIFO  = 8'h0D;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CMD     = 3'd1,
    ST_ADDR    = 3'd2,
    ST_WR_DATA = 3'd3,
    ST_RD_DATA = 3'd4,
    ST_IGNORE  = 3'd5
  } spi_state_e;

endpackage

// File: rtl/adxl362_spi_sync.sv
// N-stage synchronizer for an asynchronous SPI pin, with one-cycle rise/fall
// strobes derived from the synchronized level. All flops clear to 0, so a pin
// that is high when reset releases shows up as a rise, never as a fall.
module adxl362_spi_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_16mhz,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // shift the pin through the synchronizer and remember the previous level
  always_ff @(posedge clk_16mhz or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/adxl362_spi_slave.sv
// ADXL362 SPI slave front end (mode 0, MSB first), oversampled on clk_16mhz.
// Decodes command/address/data bytes and drives the register file port.
//
// state      | meaning
// -----------+--------------------------------------------------------
// ST_IDLE    | waiting for a cs_n fall
// ST_CMD     | receiving command byte
// ST_ADDR    | receiving address byte
// ST_WR_DATA | receiving write data bytes, one write pulse per byte
// ST_RD_DATA | shifting register bytes out on MISO
// ST_IGNORE  | unsupported command, swallow bytes until cs_n high
module adxl362_spi_slave #(
  parameter int SYNC_STAGES   = 2,
  parameter int WR_PULSE_CLKS = 2
) (
  input  logic       clk_16mhz,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       mosi,
  input  logic       cs_n,
  output logic       miso,
  output logic       miso_oe,
  output logic [5:0] address,
  output logic [7:0] data_write,
  output logic       write,
  input  logic [7:0] data_read,
  output logic       busy
);
  import adxl362_spi_slave_pkg::*;

  localparam int WR_CNT_W = $clog2(WR_PULSE_CLKS + 1);
  localparam logic [WR_CNT_W-1:0] WR_CNT_INIT = WR_CNT_W'(WR_PULSE_CLKS - 1);

  spi_state_e          state;
  logic                is_read;
  logic [2:0]          bit_cnt;
  logic [7:0]          rx;
  logic [7:0]          tx;
  logic                load_pend;
  logic                wr_pend;
  logic [WR_CNT_W-1:0] wr_cnt;
  logic                inc_pend;
  logic                armed;

  logic sclk_level_unused;
  logic sclk_rise, sclk_fall;
  logic cs_s, cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] mosi_q;
  logic mosi_s;
  logic [7:0] rx_next;
  logic byte_done;

  adxl362_spi_sync #(.STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk_16mhz (clk_16mhz),
    .rst_n     (rst_n),
    .din       (sclk),
    .level     (sclk_level_unused),
    .rise      (sclk_rise),
    .fall      (sclk_fall)
  );

  adxl362_spi_sync #(.STAGES(SYNC_STAGES)) u_sync_cs (
    .clk_16mhz (clk_16mhz),
    .rst_n     (rst_n),
    .din       (cs_n),
    .level     (cs_s),
    .rise      (cs_rise),
    .fall      (cs_fall)
  );

  // mosi uses the same depth as sclk so data and clock stay aligned
  always_ff @(posedge clk_16mhz or negedge rst_n) begin
    if (!rst_n) mosi_q <= '0;
    else        mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi};
  end

  assign mosi_s    = mosi_q[SYNC_STAGES-1];
  assign rx_next   = {rx[6:0], mosi_s};
  assign byte_done = sclk_rise && (bit_cnt == 3'd7);
  // busy only after cs_n has been seen high once since reset
  assign busy      = armed & ~cs_s;

  // protocol FSM, shift registers, write pulse timer and address counter
  always_ff @(posedge clk_16mhz or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      is_read    <= 1'b0;
      bit_cnt    <= 3'd0;
      rx         <= 8'h00;
      tx         <= 8'h00;
      miso       <= 1'b0;
      miso_oe    <= 1'b0;
      load_pend  <= 1'b0;
      address    <= 6'h00;
      data_write <= 8'h00;
      write      <= 1'b0;
      wr_pend    <= 1'b0;
      wr_cnt     <= '0;
      inc_pend   <= 1'b0;
      armed      <= 1'b0;
    end else begin
      if (cs_rise) armed <= 1'b1;

      // the write pulse runs independently of the FSM so an in-flight pulse
      // still completes after cs_n goes high
      if (wr_pend) begin
        write   <= 1'b1;
        wr_cnt  <= WR_CNT_INIT;
        wr_pend <= 1'b0;
      end else if (write) begin
        if (wr_cnt == '0) begin
          write    <= 1'b0;
          inc_pend <= 1'b1;
        end else begin
          wr_cnt <= wr_cnt - 1'b1;
        end
      end

      // post-write increment is dropped if the transfer was closed meanwhile
      if (inc_pend) begin
        inc_pend <= 1'b0;
        if (state == ST_WR_DATA) address <= address + 6'd1;
      end

      if (state != ST_IDLE && cs_s) begin
        state     <= ST_IDLE;
        bit_cnt   <= 3'd0;
        miso      <= 1'b0;
        miso_oe   <= 1'b0;
        load_pend <= 1'b0;
      end else begin
        if (state != ST_IDLE && sclk_rise) begin
          rx      <= rx_next;
          bit_cnt <= bit_cnt + 3'd1;
        end

        if (state == ST_RD_DATA && sclk_fall) begin
          if (load_pend) begin
            tx        <= data_read;
            miso      <= data_read[7];
            miso_oe   <= 1'b1;
            load_pend <= 1'b0;
          end else begin
            tx   <= {tx[6:0], 1'b0};
            miso <= tx[6];
          end
        end

        case (state)
          ST_IDLE: begin
            if (cs_fall) begin
              state   <= ST_CMD;
              bit_cnt <= 3'd0;
              rx      <= 8'h00;
            end
          end
          ST_CMD: begin
            if (byte_done) begin
              if (rx_next == ADXL362_CMD_WRITE) begin
                is_read <= 1'b0;
                state   <= ST_ADDR;
              end else if (rx_next == ADXL362_CMD_READ) begin
                is_read <= 1'b1;
                state   <= ST_ADDR;
              end else begin
                state <= ST_IGNORE;
              end
            end
          end
          ST_ADDR: begin
            if (byte_done) begin
              address   <= rx_next[5:0];
              load_pend <= is_read;
              state     <= is_read ? ST_RD_DATA : ST_WR_DATA;
            end
          end
          ST_WR_DATA: begin
            if (byte_done) begin
              data_write <= rx_next;
              wr_pend    <= 1'b1;
            end
          end
          ST_RD_DATA: begin
            if (byte_done) begin
              address   <= address + 6'd1;
              load_pend <= 1'b1;
            end
          end
          ST_IGNORE: begin
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_adxl362_spi_slave.sv
// Directed bench for adxl362_spi_slave: mode-0 SPI master at clk/8 and a
// 64-byte register file model with ADXL362 ID values at 0x00..0x03.
module tb_adxl362_spi_slave;

  localparam int SYNC       = 2;
  localparam int WRW        = 2;
  localparam int CLK_HALF   = 31;
  localparam int HALF       = 4;
  localparam time WR_LAT    = time'((2 + SYNC) * 2 * CLK_HALF - CLK_HALF);

  logic       clk_16mhz = 1'b0;
  logic       rst_n;
  logic       sclk, mosi, cs_n;
  logic       miso, miso_oe, write, busy;
  logic [5:0] address;
  logic [7:0] data_write, data_read;

  int checks   = 0;
  int failures = 0;

  logic [7:0] regs [64] = '{0: 8'hAD, 1: 8'h1D, 2: 8'hF2, 3: 8'h01, default: 8'h00};
  int         wr_count  = 0;
  logic [5:0] wr_addr_q [$];
  logic [7:0] wr_data_q [$];
  time        wr_rise_t = 0;
  time        last_rise_t = 0;
  int         oe_cycles = 0;

  always #CLK_HALF clk_16mhz = ~clk_16mhz;

  adxl362_spi_slave #(.SYNC_STAGES(SYNC), .WR_PULSE_CLKS(WRW)) dut (
    .clk_16mhz  (clk_16mhz),
    .rst_n      (rst_n),
    .sclk       (sclk),
    .mosi       (mosi),
    .cs_n       (cs_n),
    .miso       (miso),
    .miso_oe    (miso_oe),
    .address    (address),
    .data_write (data_write),
    .write      (write),
    .data_read  (data_read),
    .busy       (busy)
  );

  assign data_read = regs[address];

  always @(posedge write) begin
    wr_count++;
    wr_addr_q.push_back(address);
    wr_data_q.push_back(data_write);
    wr_rise_t = $time;
    regs[address] = data_write;
  end

  always @(posedge clk_16mhz) if (miso_oe === 1'b1) oe_cycles++;

  task automatic spi_bits(input logic [7:0] tx_b, input int nbits,
                          output logic [7:0] rx_b, output logic oe_all, output logic oe_any);
    rx_b = 8'h00; oe_all = 1'b1; oe_any = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      mosi = tx_b[7-i];
      repeat (HALF) @(negedge clk_16mhz);
      sclk = 1'b1;
      last_rise_t = $time;
      rx_b   = {rx_b[6:0], miso};
      oe_all = oe_all & miso_oe;
      oe_any = oe_any | miso_oe;
      repeat (HALF) @(negedge clk_16mhz);
      sclk = 1'b0;
    end
  endtask

  task automatic spi_byte(input logic [7:0] tx_b, output logic [7:0] rx_b,
                          output logic oe_all, output logic oe_any);
    spi_bits(tx_b, 8, rx_b, oe_all, oe_any);
  endtask

  task automatic cs_begin();
    cs_n = 1'b0;
    repeat (HALF) @(negedge clk_16mhz);
  endtask

  task automatic cs_end();
    repeat (HALF) @(negedge clk_16mhz);
    cs_n = 1'b1;
    repeat (8) @(negedge clk_16mhz);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; sclk = 1'b0; mosi = 1'b0; cs_n = 1'b1;
    repeat (3) @(negedge clk_16mhz);
    checks++; if ({miso, miso_oe, write, busy} !== 4'b0000) begin failures++; $display("FAIL reset_bits: got %b expected 0000", {miso, miso_oe, write, busy}); end
    checks++; if (address !== 6'h00) begin failures++; $display("FAIL reset_address: got %h expected 00", address); end
    checks++; if (data_write !== 8'h00) begin failures++; $display("FAIL reset_data_write: got %h expected 00", data_write); end
    rst_n = 1'b1;
    repeat (6) @(negedge clk_16mhz);
    checks++; if ({busy, miso_oe, write} !== 3'b000) begin failures++; $display("FAIL post_reset_idle: got %b expected 000", {busy, miso_oe, write}); end
  endtask

  task automatic test_single_write();
    logic [7:0] r; logic oa, on; int w0, oe0;
    w0 = wr_count; oe0 = oe_cycles;
    cs_begin();
    spi_byte(8'h0A, r, oa, on);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL busy_active: got %b expected 1", busy); end
    spi_byte(8'h20, r, oa, on);
    spi_byte(8'h55, r, oa, on);
    repeat (8) @(negedge clk_16mhz);
    checks++; if (wr_count - w0 !== 1) begin failures++; $display("FAIL single_write_count: got %0d expected 1", wr_count - w0); end
    checks++; if (wr_rise_t - last_rise_t !== WR_LAT) begin failures++; $display("FAIL write_latency: got %0t expected %0t", wr_rise_t - last_rise_t, WR_LAT); end
    cs_end();
    checks++; if (wr_addr_q[w0] !== 6'h20 || wr_data_q[w0] !== 8'h55) begin failures++; $display("FAIL single_write_at_rise: got %h/%h expected 20/55", wr_addr_q[w0], wr_data_q[w0]); end
    checks++; if (regs[6'h20] !== 8'h55) begin failures++; $display("FAIL thresh_act_reg: got %h expected 55", regs[6'h20]); end
    checks++; if (oe_cycles - oe0 !== 0) begin failures++; $display("FAIL write_no_oe: got %0d expected 0", oe_cycles - oe0); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL busy_idle: got %b expected 0", busy); end
  endtask

  task automatic test_burst_write();
    logic [7:0] r; logic oa, on; int w0;
    w0 = wr_count;
    cs_begin();
    spi_byte(8'h0A, r, oa, on);
    spi_byte(8'h2C, r, oa, on);
    spi_byte(8'h13, r, oa, on);
    spi_byte(8'h02, r, oa, on);
    cs_end();
    checks++; if (wr_count - w0 !== 2) begin failures++; $display("FAIL burst_write_count: got %0d expected 2", wr_count - w0); end
    else begin
      checks++; if (wr_addr_q[w0] !== 6'h2C || wr_data_q[w0] !== 8'h13) begin failures++; $display("FAIL burst_pulse0: got %h/%h expected 2c/13", wr_addr_q[w0], wr_data_q[w0]); end
      checks++; if (wr_addr_q[w0+1] !== 6'h2D || wr_data_q[w0+1] !== 8'h02) begin failures++; $display("FAIL burst_pulse1: got %h/%h expected 2d/02", wr_addr_q[w0+1], wr_data_q[w0+1]); end
    end
    checks++; if (regs[6'h2C] !== 8'h13 || regs[6'h2D] !== 8'h02) begin failures++; $display("FAIL burst_regs: got %h/%h expected 13/02", regs[6'h2C], regs[6'h2D]); end
    checks++; if (address !== 6'h2E) begin failures++; $display("FAIL burst_final_addr: got %h expected 2e", address); end
  endtask

  task automatic test_burst_read();
    logic [7:0] r; logic oa, on;
    logic [7:0] exp_rd [4] = '{8'hAD, 8'h1D, 8'hF2, 8'h01};
    cs_begin();
    spi_byte(8'h0B, r, oa, on);
    checks++; if (on !== 1'b0) begin failures++; $display("FAIL read_cmd_oe: got %b expected 0", on); end
    spi_byte(8'h00, r, oa, on);
    checks++; if (on !== 1'b0) begin failures++; $display("FAIL read_addr_oe: got %b expected 0", on); end
    for (int i = 0; i < 4; i++) begin
      spi_byte(8'h00, r, oa, on);
      checks++; if (r !== exp_rd[i]) begin failures++; $display("FAIL read_byte%0d: got %h expected %h", i, r, exp_rd[i]); end
      checks++; if (oa !== 1'b1) begin failures++; $display("FAIL read_oe%0d: got %b expected 1", i, oa); end
    end
    cs_end();
    checks++; if (miso_oe !== 1'b0 || miso !== 1'b0) begin failures++; $display("FAIL read_end_oe: got %b%b expected 00", miso_oe, miso); end
    checks++; if (address !== 6'h04) begin failures++; $display("FAIL read_final_addr: got %h expected 04", address); end
  endtask

  task automatic test_abort();
    logic [7:0] r; logic oa, on; int w0;
    cs_begin();
    spi_byte(8'h0A, r, oa, on); spi_byte(8'h21, r, oa, on); spi_byte(8'h3C, r, oa, on);
    cs_end();
    w0 = wr_count;
    cs_begin();
    spi_byte(8'h0A, r, oa, on); spi_byte(8'h21, r, oa, on);
    spi_bits(8'hFF, 5, r, oa, on);
    cs_end();
    repeat (8) @(negedge clk_16mhz);
    checks++; if (wr_count - w0 !== 0) begin failures++; $display("FAIL abort_no_write: got %0d expected 0", wr_count - w0); end
    checks++; if (address !== 6'h21 || data_write !== 8'h3C) begin failures++; $display("FAIL abort_hold: got %h/%h expected 21/3c", address, data_write); end
    cs_begin();
    spi_byte(8'h0B, r, oa, on); spi_byte(8'h21, r, oa, on); spi_byte(8'h00, r, oa, on);
    cs_end();
    checks++; if (r !== 8'h3C) begin failures++; $display("FAIL abort_readback: got %h expected 3c", r); end
  endtask

  task automatic test_ignore_and_wrap();
    logic [7:0] r; logic oa, on; int w0, oe0;
    logic [7:0] acc;
    w0 = wr_count; oe0 = oe_cycles; acc = 8'h00;
    cs_begin();
    spi_byte(8'h0D, r, oa, on);
    for (int i = 0; i < 3; i++) begin
      spi_byte(8'hA5, r, oa, on);
      acc = acc | r;
    end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL ignore_busy: got %b expected 1", busy); end
    cs_end();
    checks++; if (wr_count - w0 !== 0 || oe_cycles - oe0 !== 0) begin failures++; $display("FAIL ignore_quiet: got writes %0d oe %0d expected 0 0", wr_count - w0, oe_cycles - oe0); end
    checks++; if (acc !== 8'h00) begin failures++; $display("FAIL ignore_miso: got %h expected 00", acc); end
    cs_begin();
    spi_byte(8'h0B, r, oa, on); spi_byte(8'h3F, r, oa, on);
    spi_byte(8'h00, r, oa, on);
    checks++; if (r !== 8'h00) begin failures++; $display("FAIL wrap_byte0: got %h expected 00", r); end
    spi_byte(8'h00, r, oa, on);
    checks++; if (r !== 8'hAD) begin failures++; $display("FAIL wrap_byte1: got %h expected ad", r); end
    cs_end();
    checks++; if (address !== 6'h01) begin failures++; $display("FAIL wrap_final_addr: got %h expected 01", address); end
  endtask

  task automatic test_reset_mid_read();
    logic [7:0] r; logic oa, on;
    cs_begin();
    spi_byte(8'h0B, r, oa, on); spi_byte(8'h01, r, oa, on);
    spi_byte(8'h00, r, oa, on);
    checks++; if (r !== 8'h1D) begin failures++; $display("FAIL pre_reset_read: got %h expected 1d", r); end
    spi_bits(8'h00, 3, r, oa, on);
    rst_n = 1'b0;
    #1;
    checks++; if ({miso, miso_oe, write, busy, address, data_write} !== 18'h0) begin failures++; $display("FAIL mid_reset_outputs: got %h expected 0", {miso, miso_oe, write, busy, address, data_write}); end
    sclk = 1'b0; cs_n = 1'b1;
    repeat (4) @(negedge clk_16mhz);
    rst_n = 1'b1;
    repeat (6) @(negedge clk_16mhz);
    cs_begin();
    spi_byte(8'h0B, r, oa, on); spi_byte(8'h02, r, oa, on); spi_byte(8'h00, r, oa, on);
    cs_end();
    checks++; if (r !== 8'hF2) begin failures++; $display("FAIL post_reset_read: got %h expected f2", r); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_burst_write();
    test_burst_read();
    test_abort();
    test_ignore_and_wrap();
    test_reset_mid_read();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
